// File: rtl/sort_pkg.sv
// Shared definitions for the in-place bubble-sort controller: FSM states,
// default geometry and the reference memory preload image.
package sort_pkg;

    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_LAST_ADDR = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LAST,
        READ_A,
        READ_B,
        CMP,
        SWAP_LO,
        SWAP_HI,
        FINISH
    } state_t;

    // Index 15 is leftmost: cells 0..7 hold the array, cell 8 the last index.
    localparam logic [2**DEF_ADDR_W-1:0][DEF_DATA_W-1:0] PRELOAD = {
        8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h90,
        8'd7,
        8'd8, 8'd5, 8'd4, 8'd6, 8'd1, 8'd2, 8'd3, 8'd7
    };

endpackage

// File: rtl/sort_controller.sv
// Sequences a 16x8 memory (combinational read, synchronous write) through an
// ascending unsigned bubble sort with early exit, counting swaps.
module sort_controller
    import sort_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LAST_ADDR = DEF_LAST_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] swap_count,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_M1_A = ADDR_W'(LAST_ADDR - 1);
    localparam logic [DATA_W-1:0] LAST_M1_D = DATA_W'(LAST_ADDR - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W-1:0]   lim_q, lim_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                swapped_q, swapped_d;
    logic [DATA_W-1:0]   swap_count_q, swap_count_d;
    logic                advance;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + DATA_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            i_q          <= '0;
            lim_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            lim_q        <= lim_d;
            a_q          <= a_d;
            b_q          <= b_d;
            swapped_q    <= swapped_d;
            swap_count_q <= swap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        lim_d        = lim_q;
        a_d          = a_q;
        b_d          = b_q;
        swapped_d    = swapped_q;
        swap_count_d = swap_count_q;
        advance      = 1'b0;
        mem_raddr    = '0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD_LAST;
                    swap_count_d = '0;
                end
            end
            LOAD_LAST: begin
                mem_raddr = LAST_A;
                // Clamp at full data width so large counts cannot wrap into range.
                lim_d = (mem_rdata > LAST_M1_D) ? LAST_M1_A : mem_rdata[ADDR_W-1:0];
                if (lim_d == '0) begin
                    state_d = FINISH;
                end else begin
                    i_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = READ_A;
                end
            end
            READ_A: begin
                mem_raddr = i_q;
                a_d       = mem_rdata;
                state_d   = READ_B;
            end
            READ_B: begin
                mem_raddr = i_q + ADDR_W'(1);
                b_d       = mem_rdata;
                state_d   = CMP;
            end
            CMP: begin
                if (a_q > b_q) state_d = SWAP_LO;
                else           advance = 1'b1;
            end
            SWAP_LO: begin
                mem_we    = 1'b1;
                mem_waddr = i_q;
                mem_wdata = b_q;
                state_d   = SWAP_HI;
            end
            SWAP_HI: begin
                mem_we       = 1'b1;
                mem_waddr    = i_q + ADDR_W'(1);
                mem_wdata    = a_q;
                swapped_d    = 1'b1;
                swap_count_d = sat_inc(swap_count_q);
                advance      = 1'b1;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // swapped_d already reflects a swap completed in this cycle.
        if (advance) begin
            if ((i_q + ADDR_W'(1)) < lim_q) begin
                i_d     = i_q + ADDR_W'(1);
                state_d = READ_A;
            end else if (!swapped_d || lim_q == ADDR_W'(1)) begin
                state_d = FINISH;
            end else begin
                lim_d     = lim_q - ADDR_W'(1);
                i_d       = '0;
                swapped_d = 1'b0;
                state_d   = READ_A;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_sort_controller.sv
// Bench for sort_controller: memory model, directed vector table, reset and
// start-while-busy sequences, and randomized arrays against a reference sort.
module tb_sort_controller;
    import sort_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, mem_we;
    logic [7:0] swap_count, mem_rdata, mem_wdata;
    logic [3:0] mem_raddr, mem_waddr;

    logic [7:0] mem [16];
    logic [7:0] img [16];
    logic [7:0] exp_mem [16];
    logic       mem_reload = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int bad_addr = 0;

    sort_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_raddr];

    always @(posedge clk) begin
        if (mem_reload) begin
            for (int k = 0; k < 16; k++) mem[k] <= img[k];
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_we) we_cnt++;
        if (mem_raddr > 4'd8 || (mem_we && mem_waddr > 4'd8)) bad_addr++;
    end

    typedef struct {
        logic [0:7][7:0] arr;
        logic [7:0]      last;
        logic [0:7][7:0] exp_arr;
        int              exp_swaps;
        int              exp_lat;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_img(input logic [0:7][7:0] arr, input logic [7:0] last);
        logic [15:0][7:0] pre;
        pre = PRELOAD;
        for (int k = 0; k < 8; k++) img[k] = arr[k];
        img[8] = last;
        for (int k = 9; k < 16; k++) img[k] = pre[k];
    endtask

    task automatic reload_mem();
        @(negedge clk);
        mem_reload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_reload = 1'b0;
    endtask

    // lat counts negedges after the start-sampling edge until done is seen.
    task automatic run_sort(input bit poke_start, output int lat);
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            start = (poke_start && (c == 5 || c == 40)) ? 1'b1 : 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    // Reference: plain bubble sort with early exit over exp_mem.
    function automatic void ref_sort(output int sw, output int lat);
        int lim, cmp;
        bit any;
        logic [7:0] t;
        lim = (exp_mem[8] > 8'd7) ? 7 : int'(exp_mem[8]);
        sw = 0;
        cmp = 0;
        while (lim > 0) begin
            any = 1'b0;
            for (int i = 0; i < lim; i++) begin
                cmp++;
                if (exp_mem[i] > exp_mem[i+1]) begin
                    t = exp_mem[i];
                    exp_mem[i] = exp_mem[i+1];
                    exp_mem[i+1] = t;
                    sw++;
                    any = 1'b1;
                end
            end
            if (!any || lim == 1) break;
            lim--;
        end
        lat = 2 + 3 * cmp + 2 * sw;
    endfunction

    task automatic run_and_check(input string tag, input int exp_sw, input int exp_lat,
                                 input bit poke_start);
        int lat, d0, w0, b0;
        d0 = done_cnt;
        w0 = we_cnt;
        b0 = bad_addr;
        run_sort(poke_start, lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_swaps"}, int'(swap_count), exp_sw);
        @(negedge clk);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_done_after"}, int'(done), 0);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_writes"}, we_cnt - w0, 2 * exp_sw);
        check({tag, "_bad_addr"}, bad_addr - b0, 0);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s_cell%0d", tag, k), int'(mem[k]), int'(exp_mem[k]));
    endtask

    initial begin
        int n, sw, lat;
        bit prev;
        logic [0:7][7:0] ra;
        logic [7:0] snap [16];
        int w0;

        tbl[0] = '{arr: {8'd7,8'd3,8'd2,8'd1,8'd6,8'd4,8'd5,8'd8}, last: 8'd7,
                   exp_arr: {8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8}, exp_swaps: 11, exp_lat: 90};
        tbl[1] = '{arr: {8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8}, last: 8'd7,
                   exp_arr: {8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8}, exp_swaps: 0, exp_lat: 23};
        tbl[2] = '{arr: {8'd7,8'd3,8'd2,8'd1,8'd6,8'd4,8'd5,8'd8}, last: 8'd0,
                   exp_arr: {8'd7,8'd3,8'd2,8'd1,8'd6,8'd4,8'd5,8'd8}, exp_swaps: 0, exp_lat: 2};
        tbl[3] = '{arr: {8'd3,8'd2,8'd1,8'd6,8'd4,8'd5,8'd8,8'd7}, last: 8'd2,
                   exp_arr: {8'd1,8'd2,8'd3,8'd6,8'd4,8'd5,8'd8,8'd7}, exp_swaps: 3, exp_lat: 17};
        tbl[4] = '{arr: {8'd7,8'd3,8'd2,8'd1,8'd6,8'd4,8'd5,8'd8}, last: 8'd200,
                   exp_arr: {8'd1,8'd2,8'd3,8'd4,8'd5,8'd6,8'd7,8'd8}, exp_swaps: 11, exp_lat: 90};

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_swap_count", int'(swap_count), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_raddr", int'(mem_raddr), 0);
        check("rst_waddr", int'(mem_waddr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            set_img(tbl[v].arr, tbl[v].last);
            reload_mem();
            for (int k = 0; k < 16; k++) exp_mem[k] = (k < 8) ? tbl[v].exp_arr[k] : img[k];
            run_and_check($sformatf("vec%0d", v), tbl[v].exp_swaps, tbl[v].exp_lat, 1'b0);
        end

        // Reset asserted during the third SWAP_LO of the default sort.
        set_img(tbl[0].arr, tbl[0].last);
        reload_mem();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 200 && n < 3; c++) begin
            if (mem_we && !prev) n++;
            prev = mem_we;
            if (n < 3) @(negedge clk);
        end
        check("rst_mid_reached_swap3", n, 3);
        reset = 1'b1;
        #1;
        w0 = we_cnt;
        for (int k = 0; k < 16; k++) snap[k] = mem[k];
        @(negedge clk);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_we", int'(mem_we), 0);
        check("rst_mid_swap_count", int'(swap_count), 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid_no_writes", we_cnt - w0, 0);
        n = 0;
        for (int k = 0; k < 16; k++) if (mem[k] !== snap[k]) n++;
        check("rst_mid_mem_frozen", n, 0);
        reset = 1'b0;

        // Fresh sort after reset, with start pulsed while busy.
        reload_mem();
        for (int k = 0; k < 16; k++) exp_mem[k] = (k < 8) ? tbl[0].exp_arr[k] : img[k];
        run_and_check("after_rst", 11, 90, 1'b1);

        // Randomized arrays and last-index values against the reference sort.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < 8; k++)
                ra[k] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            set_img(ra, (r % 5 == 4) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7)));
            reload_mem();
            for (int k = 0; k < 16; k++) exp_mem[k] = img[k];
            ref_sort(sw, lat);
            run_and_check($sformatf("rnd%0d", r), sw, lat, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_controller.md
Name: sort_controller

Overview:
- FSM that sequences the 16x8 data memory to bubble-sort its array region in place, ascending, unsigned.
- Memory has one combinational read port (read address in, data out same cycle) and one synchronous write port with a write enable.
- The controller reads the element count from a fixed "last index" cell, then performs compare/swap passes with early exit.
- Sits between the top-level start/done interface and the memory's readselect/writeselect/write-enable/data pins.

Parameters:
- ADDR_W, 4, memory address width
- DATA_W, 8, memory word width
- LAST_ADDR, 8, address of the cell holding the index of the final array element; the array occupies addresses 0..LAST_ADDR-1

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  begin a sort; sampled only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when a sort completes
- swap_count  output  DATA_W  number of swaps in the last/current sort; saturates at all-ones
- mem_raddr  output  ADDR_W  memory read select
- mem_rdata  input  DATA_W  memory read data (combinational from mem_raddr)
- mem_we  output  1  memory write enable
- mem_waddr  output  ADDR_W  memory write select
- mem_wdata  output  DATA_W  memory write data

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, swap_count=0, mem_we=0, mem_raddr=0, mem_waddr=0, mem_wdata=0; internal i, lim, a, b and swapped all cleared.
- Outputs are registered or decoded from state only. mem_we is high only in SWAP_LO and SWAP_HI.
- States and transitions:
  - IDLE: if start=1, go to LOAD_LAST and clear swap_count. Otherwise stay.
  - LOAD_LAST: mem_raddr=LAST_ADDR. Latch lim = min(mem_rdata, LAST_ADDR-1), comparing at full DATA_W width before truncation. If lim==0, go to FINISH. Else set i=0, swapped=0, go to READ_A.
  - READ_A: mem_raddr=i; a<=mem_rdata; go to READ_B.
  - READ_B: mem_raddr=i+1; b<=mem_rdata; go to CMP.
  - CMP: if a>b (unsigned), go to SWAP_LO. Otherwise apply the ADVANCE rule.
  - SWAP_LO: mem_we=1, mem_waddr=i, mem_wdata=b; go to SWAP_HI.
  - SWAP_HI: mem_we=1, mem_waddr=i+1, mem_wdata=a; set swapped=1; increment swap_count (saturating); apply the ADVANCE rule, with this swap counted in swapped.
  - ADVANCE rule:
    - If i+1 < lim: i<=i+1, go to READ_A.
    - Else (end of pass): if swapped==0 or lim==1, go to FINISH. Otherwise lim<=lim-1, i<=0, swapped<=0, go to READ_A.
  - FINISH: done=1 for exactly this cycle, busy=1; go to IDLE.
- Latency:
  - Non-swap compare: 3 cycles. Swapping compare: 5 cycles.
  - If start is sampled at edge 0, LOAD_LAST occupies cycle 1.
- start asserted while busy: ignored; no queuing.
- start held high through FINISH: a new sort begins on the edge after returning to IDLE. Sorting an already-sorted array is legal and gives 0 swaps.
- Reset mid-operation: immediate return to IDLE; no further writes. Memory contents may be partially sorted; the memory's own reset restores its preload.
- mem_raddr and mem_waddr never address outside 0..LAST_ADDR.
- Any lim value loaded from memory that is at or above LAST_ADDR is clamped to LAST_ADDR-1.

Decomposition:
- Shared package sort_pkg holds:
  - the state enum (IDLE, LOAD_LAST, READ_A, READ_B, CMP, SWAP_LO, SWAP_HI, FINISH)
  - default ADDR_W, DATA_W and LAST_ADDR constants
  - the preload-vector constant used by benches
- No sub-module. The comparator and saturating counter are inline; a single module is natural.

Test Plan:
- Default preload [7,3,2,1,6,4,5,8], last=7, pulse start -> memory 0..7 reads [1,2,3,4,5,6,7,8]; swap_count=11; done pulses once; busy falls with done.
- Preload already sorted [1..8], last=7 -> zero mem_we cycles; swap_count=0; done high exactly 23 cycles after the start-sampling edge.
- last=0 -> done on cycle 2 after start; no writes; array unchanged.
- last=2 with [3,2,1] -> [1,2,3]; swap_count=3; cells 3..15 untouched.
- last=200 (clamped to 7) with the default array -> same result as the first scenario; no access beyond address 8.
- Assert reset during the third SWAP_LO -> busy=0 next cycle; no write on later cycles; a fresh start after reset sorts the reloaded preload correctly. Also pulse start while busy -> no effect on the sequence.
